// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store target with fixed latency.
// Optional misalignment error reporting under DMEM_ALIGN_CHK_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int RD_LATENCY  = 2,
  parameter int WR_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        rollback,
  output logic        rd_ready,
  output logic [31:0] rd_data,
  output logic        wr_ready,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [15:0] RD_L1 = 16'(RD_LATENCY - 1);
  localparam logic [15:0] WR_L1 = 16'(WR_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [15:0]   r_cnt;
  logic          r_we;
  logic [1:0]    r_size;
  logic          r_uns;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic          r_rd_ready;
  logic          r_wr_ready;
  logic [31:0]   r_rd_data;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_resp;
  logic          w_mis;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [7:0]    w_b;
  logic [15:0]   w_h;
  logic [31:0]   w_load;
  logic [31:0]   w_wsh;
  logic [3:0]    w_be;
  logic          w_unused;

  assign w_unused = &{1'b0, req_addr[31:AW+2]};
  assign w_idx    = r_addr[AW+1:2];
  assign w_word   = r_mem[w_idx];

  assign rd_ready = r_rd_ready;
  assign wr_ready = r_wr_ready;
  assign rd_data  = r_rd_data;

`ifdef DMEM_ALIGN_CHK_EN
  logic r_err;

  assign w_mis = (r_size == 2'b01 && r_addr[0])
              || (r_size[1] && r_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_resp & w_mis;
    end
  end

  assign err = r_err;
`else
  assign w_mis = 1'b0;
  assign err   = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    w_accept  = 1'b0;
    w_resp    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        req_ready = ~rollback;
        w_accept  = req_valid & ~rollback;
        if (w_accept) begin
          w_next = S_BUSY;
        end
      end
      S_BUSY: begin
        // Rollback wins even on the response edge: no pulse, no write.
        if (rollback) begin
          w_next = S_IDLE;
        end else if (r_cnt == 16'd0) begin
          w_resp = 1'b1;
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_uns      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd_ready <= 1'b0;
      r_wr_ready <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_ready <= w_resp & ~r_we;
      r_wr_ready <= w_resp & r_we;
      if (w_accept) begin
        r_we    <= req_we;
        r_size  <= req_size;
        r_uns   <= req_unsigned;
        r_addr  <= req_addr[AW+1:0];
        r_wdata <= req_wdata;
        r_cnt   <= req_we ? WR_L1 : RD_L1;
      end else if (r_state == S_BUSY && r_cnt != 16'd0) begin
        r_cnt <= r_cnt - 16'd1;
      end
      if (w_resp && !r_we) begin
        r_rd_data <= w_mis ? 32'd0 : w_load;
      end
    end
  end

  always_comb begin
    unique case (r_addr[1:0])
      2'd0:    w_b = w_word[7:0];
      2'd1:    w_b = w_word[15:8];
      2'd2:    w_b = w_word[23:16];
      default: w_b = w_word[31:24];
    endcase
    w_h    = r_addr[1] ? w_word[31:16] : w_word[15:0];
    w_load = w_word;
    unique case (1'b1)
      (r_size == 2'b00): w_load = {{24{~r_uns & w_b[7]}}, w_b};
      (r_size == 2'b01): w_load = {{16{~r_uns & w_h[15]}}, w_h};
      default:           w_load = w_word;
    endcase
  end

  always_comb begin
    w_be  = 4'b1111;
    w_wsh = r_wdata;
    unique case (1'b1)
      (r_size == 2'b00): begin
        w_wsh = {4{r_wdata[7:0]}};
        w_be  = 4'b0001 << r_addr[1:0];
      end
      (r_size == 2'b01): begin
        w_wsh = {2{r_wdata[15:0]}};
        w_be  = r_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_be = 4'b1111;
      end
    endcase
  end

  // Array is deliberately not reset; writes only on a live response edge.
  always_ff @(posedge clk) begin
    if (rst && w_resp && r_we && !w_mis) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wsh[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target end of the load/store request interface driven by the LSQ.
- Accepts one request at a time and models configurable read and write latency.
- Performs little-endian byte, half and word accesses on an internal word array.
- Returns one-cycle rd_ready/wr_ready completion pulses, with load data, to the LSQ. Supports rollback abort of an in-flight access.

Parameters:
- DEPTH_WORDS, 128, number of 32-bit words; power of two.
- RD_LATENCY, 2, cycles from request acceptance to the rd_ready pulse; must be >=1.
- WR_LATENCY, 1, cycles from request acceptance to the wr_ready pulse; must be >=1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low; sampled at rising edge of clk.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; accept = req_valid & req_ready at an edge.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- req_unsigned  in  1  load zero-extend (1) or sign-extend (0).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rollback  in  1  abort any in-flight access (misprediction recovery).
- rd_ready  out  1  one-cycle pulse: load complete, rd_data valid.
- rd_data  out  32  extended load result.
- wr_ready  out  1  one-cycle pulse: store complete.
- err  out  1  only with DMEM_ALIGN_CHK_EN; see Optional Feature.

Behaviour:
- Reset (rst==0 at edge): state IDLE; latency counter 0; rd_ready, wr_ready and err = 0; rd_data = 0; latched request cleared. Memory array is not reset.
- FSM states IDLE, BUSY, RESP.
- IDLE:
  - req_ready = ~rollback.
  - On accept, latch we/size/unsigned/addr/wdata.
  - Load counter with (req_we ? WR_LATENCY : RD_LATENCY) - 1.
  - Go to BUSY if the loaded value is >0, else go directly to the response edge.
- BUSY:
  - req_ready = 0; counter decrements each edge.
  - When counter==0, that edge is the response edge: state -> RESP.
  - Load: register rd_data and set rd_ready = 1.
  - Store: write the array and set wr_ready = 1.
- RESP:
  - Outputs hold for exactly one cycle, then clear; state -> IDLE. req_ready = 0 during RESP.
  - Back-to-back throughput is one request per LATENCY+1 cycles.
- Response timing: the pulse is high in the cycle following the LATENCY-th edge after the accept edge. Example: RD_LATENCY=2, accept at edge 0, rd_ready high between edges 2 and 3.
- Word index = addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so accesses wrap modulo the array size.
- Load extraction:
  - Byte lane addr[1:0], half lane addr[1].
  - Sign- or zero-extend to 32 bits per req_unsigned; word loads are unchanged.
- Store merge: only the addressed bytes are modified (byte: 1 lane; half: 2 lanes; word: all). Read-modify-write is done within the response edge.
- rd_data holds its last value after rd_ready drops. rd_data is never updated by stores.
- Rollback:
  - rollback=1 at an edge in BUSY, or at the response edge: state -> IDLE with no pulse; an aborted store never modifies memory.
  - rollback in RESP: no effect; the pulse already issued completes normally.
  - rollback in IDLE blocks acceptance in that cycle.
- Reset mid-operation: same as reset; the in-flight store is discarded.
- Simultaneous req_valid while not in IDLE: ignored; the requester must hold the request until accepted.

Optional Feature:
- Macro DMEM_ALIGN_CHK_EN.
- When defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, is misaligned.
  - At its response edge it asserts err=1 together with rd_ready/wr_ready for one cycle.
  - A misaligned store does not modify memory; a misaligned load returns rd_data=0.
- When undefined:
  - err is tied 0.
  - Misaligned accesses ignore the low address bits below the access size: half uses addr[1], word uses the whole word.

Test Plan:
- Reset/idle: rst=0 for 2 cycles, then release -> req_ready=1, rd_ready=0, wr_ready=0, rd_data=0.
- Store word 0xDEADBEEF to 0x10, then load word from 0x10 (defaults) -> wr_ready pulses 1 cycle after accept; rd_ready pulses 2 cycles after accept with rd_data=0xDEADBEEF; req_ready=0 while busy.
- Store byte 0x80 to 0x13, then load signed byte at 0x13 -> 0xFFFFFF80; unsigned byte -> 0x00000080; load word 0x10 -> 0x80ADBEEF.
- Abort: store word 0x12345678 to 0x20, rollback=1 in the BUSY cycle (WR_LATENCY=2) -> no wr_ready; subsequent load of 0x20 returns the prior contents.
- Wrap: DEPTH_WORDS=128, store word 0xA5A5A5A5 to 0x204, load word from 0x004 -> 0xA5A5A5A5.
- With DMEM_ALIGN_CHK_EN: load word from 0x22 -> rd_ready and err both pulse 1 cycle, rd_data=0. Store half to 0x21 -> wr_ready and err pulse; memory unchanged.
